// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing controller that follows the vehicle light phase (RED=0, GREEN=1, YELLOW=2).
// Grants WALK on RED entry when a request is latched, then a blinking DON'T-WALK clearance.
module ped_signal_ctrl #(
  parameter int WALK_CYC  = 8,
  parameter int FLASH_CYC = 6,
  parameter int FLASH_DIV = 2,
  parameter int CW        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    light,
  input  logic          ped_btn,
  output logic          walk,
  output logic          dont_walk,
  output logic          flash,
  output logic [CW-1:0] countdown,
  output logic          req_pending,
  output logic          abort
);

  localparam logic [1:0] RED = 2'd0;
  localparam int BW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    prev_light;
  logic [BW-1:0] blink_cnt;
  logic          is_red;
  logic          red_entry;

  // The invalid code 3 is simply "not RED", so it aborts and can precede a RED entry.
  assign is_red    = (light == RED);
  assign red_entry = is_red && (prev_light != RED);

  // The countdown output doubles as the phase timer; it reads 0 whenever the FSM is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      prev_light  <= RED;
      blink_cnt   <= '0;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      flash       <= 1'b0;
      countdown   <= '0;
      req_pending <= 1'b0;
      abort       <= 1'b0;
    end else begin
      prev_light <= light;
      abort      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (red_entry && (req_pending || ped_btn)) begin
            state       <= ST_WALK;
            countdown   <= CW'(WALK_CYC);
            walk        <= 1'b1;
            dont_walk   <= 1'b0;
            flash       <= 1'b0;
            req_pending <= 1'b0;
          end else if (ped_btn) begin
            req_pending <= 1'b1;
          end
        end
        ST_WALK, ST_CLEAR: begin
          if (ped_btn) begin
            req_pending <= 1'b1;
          end
          // Losing RED beats timer expiry: pedestrians must never see WALK against traffic.
          if (!is_red) begin
            state     <= ST_IDLE;
            countdown <= '0;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            flash     <= 1'b0;
            abort     <= 1'b1;
          end else if (countdown == CW'(1)) begin
            if (state == ST_WALK) begin
              state     <= ST_CLEAR;
              countdown <= CW'(FLASH_CYC);
              walk      <= 1'b0;
              dont_walk <= 1'b1;
              flash     <= 1'b1;
              blink_cnt <= '0;
            end else begin
              state     <= ST_IDLE;
              countdown <= '0;
              dont_walk <= 1'b1;
              flash     <= 1'b0;
            end
          end else begin
            countdown <= countdown - CW'(1);
            if (state == ST_CLEAR) begin
              if (blink_cnt == BW'(FLASH_DIV - 1)) begin
                blink_cnt <= '0;
                dont_walk <= ~dont_walk;
              end else begin
                blink_cnt <= blink_cnt + BW'(1);
              end
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          countdown <= '0;
          walk      <= 1'b0;
          dont_walk <= 1'b1;
          flash     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ped_signal_ctrl.md
# ped_signal_ctrl

Pedestrian crossing signal controller that sits directly downstream of the traffic-light phase FSM and consumes its 2-bit `light` output (RED=0, GREEN=1, YELLOW=2). It latches pedestrian button requests and grants a WALK interval when the vehicle light enters RED. A flashing DON'T-WALK clearance interval follows each WALK. WALK and clearance are unconditionally withdrawn whenever the vehicle light is not RED.

## Interface
- `WALK_CYC`, 8, WALK interval length in clock cycles (≥1)
- `FLASH_CYC`, 6, clearance (flashing) interval length in clock cycles (≥1)
- `FLASH_DIV`, 2, cycles per half-period of the DON'T-WALK blink (≥1)
- `CW`, 4, countdown width; must hold max(WALK_CYC, FLASH_CYC)
- `clk`  input  1  clock, rising edge
- `rst_n`  input  1  reset, asynchronous, active-low
- `light`  input  2  vehicle phase from the traffic-light FSM; 3 is invalid
- `ped_btn`  input  1  pedestrian request, level, already synchronous to `clk`
- `walk`  output  1  WALK lamp
- `dont_walk`  output  1  DON'T-WALK lamp (steady or blinking)
- `flash`  output  1  high throughout the clearance interval
- `countdown`  output  CW  remaining cycles in WALK/CLEAR; 0 in IDLE
- `req_pending`  output  1  latched, not-yet-served request
- `abort`  output  1  one-cycle pulse when WALK/CLEAR is cut short

## Operation
- States: IDLE, WALK, CLEAR. All outputs are registered.
- `prev_light` register holds the previous sample of `light`.
- `red_entry` = (`light`==RED) && (`prev_light`!=RED).
- Invalid `light` (3) is treated as non-RED everywhere.
- Request latch:
  - `req_pending` sets on any cycle with `ped_btn`=1.
  - It clears on the IDLE→WALK grant.
  - If a press and a grant occur in the same cycle, the grant wins and `req_pending`=0.
  - Presses during WALK/CLEAR stay latched for the next red entry.
- IDLE → WALK when `red_entry` && (`req_pending` || `ped_btn`). Loads timer = WALK_CYC.
- WALK:
  - `walk`=1, `dont_walk`=0; timer decrements each cycle.
  - When timer==1 and `light`==RED, go to CLEAR and load timer = FLASH_CYC.
- CLEAR:
  - `walk`=0, `flash`=1; timer decrements each cycle.
  - `dont_walk` starts at 1 and toggles every FLASH_DIV cycles.
  - When timer==1, go to IDLE.
- Safety abort: in WALK or CLEAR with `light`!=RED, go to IDLE next edge and pulse `abort` for 1 cycle. The abort takes priority over timer expiry. `req_pending` is not restored.
- IDLE outputs: `walk`=0, `dont_walk`=1, `flash`=0, `countdown`=0.
- `countdown` mirrors the timer in WALK/CLEAR (WALK_CYC..1, then FLASH_CYC..1).

## Timing
- Reset, asynchronous, effective immediately, also mid-operation:
  - state=IDLE, `prev_light`=RED (no grant on the first RED after reset).
  - `walk`=0, `dont_walk`=1, `flash`=0, `countdown`=0, `req_pending`=0, `abort`=0.
- `light` becomes RED at edge k → `walk`=1 after edge k+1, provided a request is latched or `ped_btn`=1 at k+1.
- `walk` is high for exactly WALK_CYC cycles, then `flash` is high for exactly FLASH_CYC cycles, with no gap.
- Abort latency: `light` sampled non-RED at edge j → `walk`/`flash` are 0 and `dont_walk`=1 after edge j, with `abort`=1 for that one cycle.
- `req_pending` reflects a press one edge after `ped_btn` is sampled high.
- Grant is edge-triggered: holding RED without a new entry never grants, even if a request is latched during RED.

## Test plan
- Reset: assert `rst_n`=0 asynchronously mid-WALK → all outputs take reset values without waiting for `clk`; after release with RED held, no grant occurs.
- Full cycle (defaults): `ped_btn` pulse while GREEN, then bench holds RED 20 cycles → `req_pending`=1 until grant. Then:
  - `walk`=1 for 8 cycles, countdown 8..1.
  - Then `flash`=1 for 6 cycles, countdown 6..1, `dont_walk` 1,1,0,0,1,1.
  - Then IDLE, `abort` never high.
- No request: RED entry with `req_pending`=0 and `ped_btn`=0 → stays IDLE, `dont_walk`=1 steady.
- Abort:
  - `light` to GREEN on the 3rd WALK cycle → `walk`=0 next edge, `abort`=1 exactly 1 cycle, countdown=0.
  - Repeat in CLEAR; repeat with `light`=3.
- Request edges:
  - Press during WALK → `req_pending`=1 persists and is served at the next RED entry.
  - Press coincident with RED entry and no prior request → grant, `req_pending` stays 0.
- Integration with the traffic-light FSM (RED lasts 1 cycle), `ped_btn` held → `walk` high 1 cycle, then `abort` pulse, repeating every 3 cycles; `walk` is never high while `light`!=RED for more than 1 cycle.
